tl_phase_controller: RTL and testbench
======================================

TL_PHASE_CONTROLLER -- requirements
Module: tl_phase_controller

Interface
REQ-001 SHALL have parameter N_ROADS, default 2: number of approaches; legal 2..8; road 0 is the home road.
REQ-002 SHALL have parameter TW, default 8: width of the tick timer.
REQ-003 SHALL have parameters T_MIN_GREEN 10, T_MAX_GREEN 30, T_YELLOW 3, T_ALLRED 1: phase durations in ticks; all >=1 and <2^TW; T_MIN_GREEN<=T_MAX_GREEN.
REQ-004 SHALL have port clk  in  1  system clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tick  in  1  one-cycle timebase enable; all timing counts tick-high cycles.
REQ-007 SHALL have port sensor  in  N_ROADS  per-road vehicle presence, level or pulse.
REQ-008 SHALL have ports led_r, led_y, led_g  out  N_ROADS each  per-road lamps.
REQ-009 SHALL have port active_road  out  $clog2(N_ROADS)  road currently owning (or last owning) right of way.
REQ-010 SHALL have port phase_done  out  1  one-cycle pulse on each GREEN exit.

Function
REQ-011 SHALL implement states ALL_RED, GREEN, YELLOW (plus FLASH per REQ-026); outputs Moore-decoded from registered state.
REQ-012 SHALL drive all roads red except active_road, which is green in GREEN, yellow in YELLOW; in ALL_RED every road red; exactly one lamp lit per road.
REQ-013 SHALL clear elapsed tick counter on every state entry, increment on tick, saturate at 2^TW-1.
REQ-014 SHALL latch sensor[i] into demand[i] each cycle; demand[i] clears on the edge road i enters GREEN, clear winning over a simultaneous set; sensor of the road in GREEN does not set its latch.
REQ-015 SHALL treat demand[0] as 1 whenever active_road != 0 (home road return).
REQ-016 ALL_RED -> GREEN on the edge where tick=1 and elapsed==T_ALLRED-1; active_road updated to next road at that edge.
REQ-017 GREEN -> YELLOW on tick edge when elapsed>=T_MIN_GREEN-1 AND any other road has demand AND (sensor[active_road]==0 OR elapsed>=T_MAX_GREEN-1); otherwise hold green indefinitely.
REQ-018 YELLOW -> ALL_RED on tick edge with elapsed==T_YELLOW-1.
REQ-019 SHALL select next road round-robin: first road with demand searching active_road+1 upward with wrap; selection frozen at YELLOW->ALL_RED edge.
REQ-020 SHALL pulse phase_done on the cycle after GREEN->YELLOW edge, for exactly one clk.
REQ-021 SHALL make no transition on cycles with tick=0.

Reset
REQ-022 On rst_n low, SHALL immediately force state ALL_RED, active_road 0, elapsed 0, demand all 0, phase_done 0, led_r all 1, led_y/led_g all 0.
REQ-023 Reset mid-phase SHALL abandon the phase; after release, first GREEN is road 0 after T_ALLRED ticks.

Configuration
REQ-024 Macro TL_FLASH_MODE_EN SHALL compile in input flash_req (1 bit) and state FLASH.
REQ-025 With macro: flash_req=1 in GREEN forces YELLOW on next tick (min green waived); YELLOW end enters FLASH instead of ALL_RED; ALL_RED enters FLASH on next tick.
REQ-026 FLASH: led_r/led_g 0, all led_y toggle on each tick starting at 1; flash_req=0 -> ALL_RED on next tick with next road 0; demands retained.
REQ-027 Without macro: no flash_req port, no FLASH state, behaviour per REQ-011..023 only.

Structure
REQ-028 Package tl_pkg SHALL hold state enum and T_* default constants; module imports it.
REQ-029 SHALL instantiate one sub-module tl_tick_timer (tick-enabled, clear-on-entry, saturating TW-bit counter).

Verification (N_ROADS=3, T_MIN_GREEN=4, T_MAX_GREEN=8, T_YELLOW=2, T_ALLRED=1, tick every cycle)
REQ-030 Reset low mid-GREEN road 2 -> all red, active_road=0 same cycle; release -> road0 green after 1 tick.
REQ-031 No sensor for 100 ticks -> led_g[0] held 1 throughout, phase_done never pulses.
REQ-032 sensor[2] pulse at elapsed 10 of road0 green -> yellow next tick, 2 ticks yellow, 1 all-red, road2 green, one phase_done pulse.
REQ-033 Road2 green, sensor[2] held 1 -> green exactly 8 ticks, then yellow, then road0 green.
REQ-034 sensor[1], sensor[2] pulsed during road0 green -> green order 1, 2, 0.
REQ-035 TL_FLASH_MODE_EN, flash_req=1 at road0 elapsed 1 -> 2 yellow ticks, FLASH, led_y toggles each tick; flash_req=0 -> ALL_RED 1 tick -> road0 green.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light phase controller:
// state encoding and default phase durations (in ticks).
package tl_pkg;

    // Controller states. FLASH is reachable only when TL_FLASH_MODE_EN is defined.
    typedef logic [1:0] state_t;
    localparam state_t ST_ALL_RED = 2'd0;
    localparam state_t ST_GREEN   = 2'd1;
    localparam state_t ST_YELLOW  = 2'd2;
    localparam state_t ST_FLASH   = 2'd3;

    // Default phase durations in ticks.
    localparam int DEF_T_MIN_GREEN = 10;
    localparam int DEF_T_MAX_GREEN = 30;
    localparam int DEF_T_YELLOW    = 3;
    localparam int DEF_T_ALLRED    = 1;

endpackage

// File: rtl/tl_tick_timer.sv
// Elapsed-tick counter for the phase controller: cleared on state entry,
// advances only on tick, and saturates at all-ones.
module tl_tick_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          clear,
    output logic [TW-1:0] count
);

    // Clear has priority so every state starts timing from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != '1)) begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/tl_phase_controller.sv
// Traffic-light phase controller: demand-driven round-robin with a home road
// (road 0) that always reclaims the green once nobody else is waiting.
// Optional feature macro: TL_FLASH_MODE_EN adds the flash_req input and the
// FLASH state (all yellow lamps blinking on tick).
module tl_phase_controller
    import tl_pkg::*;
#(
    parameter int N_ROADS     = 2,
    parameter int TW          = 8,
    parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
    parameter int T_MAX_GREEN = DEF_T_MAX_GREEN,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_ALLRED    = DEF_T_ALLRED
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic [N_ROADS-1:0]         sensor,
`ifdef TL_FLASH_MODE_EN
    input  logic                       flash_req,
`endif
    output logic [N_ROADS-1:0]         led_r,
    output logic [N_ROADS-1:0]         led_y,
    output logic [N_ROADS-1:0]         led_g,
    output logic [$clog2(N_ROADS)-1:0] active_road,
    output logic                       phase_done
);

    localparam int RW = $clog2(N_ROADS);

    // Last-tick thresholds, sized to the timer so comparisons stay width-clean.
    localparam logic [TW-1:0] MIN_LAST    = TW'(T_MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_LAST    = TW'(T_MAX_GREEN - 1);
    localparam logic [TW-1:0] YELLOW_LAST = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] ALLRED_LAST = TW'(T_ALLRED - 1);

    state_t               state;
    state_t               state_next;
    logic [RW-1:0]        next_road;
    logic [RW-1:0]        sel_road;
    logic [N_ROADS-1:0]   demand;
    logic [N_ROADS-1:0]   eff_demand;
    logic [N_ROADS-1:0]   road_mask;
    logic [TW-1:0]        elapsed;
    logic                 other_demand;
    logic                 green_exit;
    logic                 enter_green;
    logic                 state_change;
    int                   idx;
`ifdef TL_FLASH_MODE_EN
    logic                 flash_phase;
`endif

    assign state_change = (state_next != state);
    assign enter_green  = (state == ST_ALL_RED) && (state_next == ST_GREEN);
    assign road_mask    = {{(N_ROADS-1){1'b0}}, 1'b1} << active_road;

    tl_tick_timer #(
        .TW(TW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .clear (state_change),
        .count (elapsed)
    );

    // Home road is treated as always waiting while someone else holds the green.
    always_comb begin
        eff_demand = demand;
        if (active_road != '0) begin
            eff_demand[0] = 1'b1;
        end
    end

    // Round-robin search for the next waiting road after the active one.
    always_comb begin
        other_demand = 1'b0;
        sel_road     = active_road;
        idx          = 0;
        for (int k = 1; k < N_ROADS; k++) begin
            idx = (int'(active_road) + k) % N_ROADS;
            if (eff_demand[idx] && !other_demand) begin
                other_demand = 1'b1;
                sel_road     = RW'(idx);
            end
        end
    end

    // Next-state logic; nothing moves on cycles without a tick.
    always_comb begin
        state_next = state;
        green_exit = 1'b0;
        if (tick) begin
            case (state)
                ST_ALL_RED: begin
                    if (elapsed == ALLRED_LAST) begin
                        state_next = ST_GREEN;
                    end
`ifdef TL_FLASH_MODE_EN
                    if (flash_req) begin
                        state_next = ST_FLASH;
                    end
`endif
                end
                ST_GREEN: begin
                    if (other_demand && (elapsed >= MIN_LAST) &&
                        (!sensor[active_road] || (elapsed >= MAX_LAST))) begin
                        green_exit = 1'b1;
                    end
`ifdef TL_FLASH_MODE_EN
                    if (flash_req) begin
                        green_exit = 1'b1;
                    end
`endif
                    if (green_exit) begin
                        state_next = ST_YELLOW;
                    end
                end
                ST_YELLOW: begin
                    if (elapsed == YELLOW_LAST) begin
                        state_next = ST_ALL_RED;
`ifdef TL_FLASH_MODE_EN
                        if (flash_req) begin
                            state_next = ST_FLASH;
                        end
`endif
                    end
                end
`ifdef TL_FLASH_MODE_EN
                ST_FLASH: begin
                    if (!flash_req) begin
                        state_next = ST_ALL_RED;
                    end
                end
`endif
                default: state_next = ST_ALL_RED;
            endcase
        end
    end

    // State, right-of-way ownership, frozen next-road choice and green-exit pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ALL_RED;
            active_road <= '0;
            next_road   <= '0;
            phase_done  <= 1'b0;
        end else begin
            state      <= state_next;
            phase_done <= green_exit;
            if (enter_green) begin
                active_road <= next_road;
            end
            if ((state == ST_YELLOW) && (state_next == ST_ALL_RED)) begin
                next_road <= sel_road;
            end
`ifdef TL_FLASH_MODE_EN
            if ((state == ST_FLASH) && (state_next == ST_ALL_RED)) begin
                next_road <= '0;
            end
`endif
        end
    end

    // Demand latches: set by sensors, cleared as the road takes the green.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            demand <= '0;
        end else begin
            for (int i = 0; i < N_ROADS; i++) begin
                if (enter_green && (next_road == RW'(i))) begin
                    demand[i] <= 1'b0;
                end else if (sensor[i] &&
                             !((state == ST_GREEN) && (active_road == RW'(i)))) begin
                    demand[i] <= 1'b1;
                end
            end
        end
    end

`ifdef TL_FLASH_MODE_EN
    // Flash blink phase: starts lit on entry, toggles on every tick in FLASH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_phase <= 1'b0;
        end else if ((state != ST_FLASH) && (state_next == ST_FLASH)) begin
            flash_phase <= 1'b1;
        end else if ((state == ST_FLASH) && tick) begin
            flash_phase <= ~flash_phase;
        end
    end
`endif

    // Moore lamp decode from the registered state.
    always_comb begin
        led_r = '1;
        led_y = '0;
        led_g = '0;
        case (state)
            ST_GREEN: begin
                led_r = ~road_mask;
                led_g = road_mask;
            end
            ST_YELLOW: begin
                led_r = ~road_mask;
                led_y = road_mask;
            end
`ifdef TL_FLASH_MODE_EN
            ST_FLASH: begin
                led_r = '0;
                led_y = {N_ROADS{flash_phase}};
            end
`endif
            default: begin
                led_r = '1;
            end
        endcase
    end

endmodule

// File: tb/tb_tl_phase_controller.sv
// Self-checking bench for tl_phase_controller (3 roads, short phase times,
// tick every cycle unless a test gates it). Green onsets are checked against
// a queue of expected roads pushed when the stimulus is applied.
module tb_tl_phase_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b1;
    logic [2:0] sensor = 3'b000;
`ifdef TL_FLASH_MODE_EN
    logic       flash_req = 1'b0;
`endif
    logic [2:0] led_r;
    logic [2:0] led_y;
    logic [2:0] led_g;
    logic [1:0] active_road;
    logic       phase_done;

    int         total = 0;
    int         bad = 0;
    int         exp_q[$];
    logic [2:0] prev_g = 3'b000;

    tl_phase_controller #(
        .N_ROADS     (3),
        .TW          (8),
        .T_MIN_GREEN (4),
        .T_MAX_GREEN (8),
        .T_YELLOW    (2),
        .T_ALLRED    (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .sensor      (sensor),
`ifdef TL_FLASH_MODE_EN
        .flash_req   (flash_req),
`endif
        .led_r       (led_r),
        .led_y       (led_y),
        .led_g       (led_g),
        .active_road (active_road),
        .phase_done  (phase_done)
    );

    always #5 clk = ~clk;

    // Scoreboard: each new green onset must match the next expected road.
    always @(negedge clk) begin
        int         road;
        logic [2:0] want;
        if ((led_g !== prev_g) && (led_g != 3'b000)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL green_order: got led_g=%b, expected no new green", led_g);
            end else begin
                road = exp_q.pop_front();
                want = 3'b001 << road;
                if (led_g !== want) begin
                    bad++;
                    $display("[TB] FAIL green_order: got led_g=%b, expected %b", led_g, want);
                end
            end
        end
        prev_g = led_g;
    end

    // Hard stop in case something wedges the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        sensor = 3'b000;
        repeat (3) @(negedge clk);
        total++; if (led_r !== 3'b111) begin bad++; $display("[TB] FAIL reset_led_r: got %b, expected 111", led_r); end
        total++; if (led_y !== 3'b000) begin bad++; $display("[TB] FAIL reset_led_y: got %b, expected 000", led_y); end
        total++; if (led_g !== 3'b000) begin bad++; $display("[TB] FAIL reset_led_g: got %b, expected 000", led_g); end
        total++; if (active_road !== 2'd0) begin bad++; $display("[TB] FAIL reset_active: got %0d, expected 0", active_road); end
        total++; if (phase_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_phase_done: got %b, expected 0", phase_done); end
        exp_q.push_back(0);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (led_g !== 3'b001) begin bad++; $display("[TB] FAIL first_green: got %b, expected 001", led_g); end
    endtask

    task automatic test_hold();
        int g_bad = 0;
        int pulses = 0;
        repeat (100) begin
            @(negedge clk);
            if (led_g[0] !== 1'b1) g_bad++;
            if (phase_done === 1'b1) pulses++;
        end
        total++; if (g_bad != 0) begin bad++; $display("[TB] FAIL hold_green: got %0d non-green cycles, expected 0", g_bad); end
        total++; if (pulses != 0) begin bad++; $display("[TB] FAIL hold_no_pulse: got %0d pulses, expected 0", pulses); end
    endtask

    task automatic test_single_demand();
        int hold_bad = 0;
        tick = 1'b0;
        sensor = 3'b100;
        @(negedge clk);
        sensor = 3'b000;
        repeat (4) begin
            @(negedge clk);
            if ((led_g !== 3'b001) || (led_y !== 3'b000)) hold_bad++;
        end
        total++; if (hold_bad != 0) begin bad++; $display("[TB] FAIL tick_gate: got %0d moved cycles, expected 0", hold_bad); end
        exp_q.push_back(2);
        tick = 1'b1;
        @(negedge clk);
        total++; if (led_y !== 3'b001) begin bad++; $display("[TB] FAIL yellow_entry: got %b, expected 001", led_y); end
        total++; if (phase_done !== 1'b1) begin bad++; $display("[TB] FAIL pulse_high: got %b, expected 1", phase_done); end
        @(negedge clk);
        total++; if (led_y !== 3'b001) begin bad++; $display("[TB] FAIL yellow_second: got %b, expected 001", led_y); end
        total++; if (phase_done !== 1'b0) begin bad++; $display("[TB] FAIL pulse_width: got %b, expected 0", phase_done); end
        @(negedge clk);
        total++; if (led_r !== 3'b111) begin bad++; $display("[TB] FAIL all_red: got %b, expected 111", led_r); end
        @(negedge clk);
        total++; if (active_road !== 2'd2) begin bad++; $display("[TB] FAIL road2_active: got %0d, expected 2", active_road); end
    endtask

    task automatic test_max_green();
        int gcount = 1;
        sensor = 3'b100;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (led_g[2] === 1'b1) gcount++;
            else break;
        end
        sensor = 3'b000;
        total++; if (gcount != 8) begin bad++; $display("[TB] FAIL max_green_len: got %0d, expected 8", gcount); end
        total++; if (led_y !== 3'b100) begin bad++; $display("[TB] FAIL max_green_yellow: got %b, expected 100", led_y); end
        exp_q.push_back(0);
        @(negedge clk);
        @(negedge clk);
        total++; if (led_r !== 3'b111) begin bad++; $display("[TB] FAIL max_all_red: got %b, expected 111", led_r); end
        @(negedge clk);
        total++; if (active_road !== 2'd0) begin bad++; $display("[TB] FAIL home_return: got %0d, expected 0", active_road); end
    endtask

    task automatic test_round_robin();
        int pulses = 0;
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(0);
        sensor = 3'b110;
        @(negedge clk);
        sensor = 3'b000;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (phase_done === 1'b1) pulses++;
            if (exp_q.size() == 0) break;
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL rr_done: got %0d pending, expected 0", exp_q.size()); end
        total++; if (pulses != 3) begin bad++; $display("[TB] FAIL rr_pulses: got %0d, expected 3", pulses); end
        total++; if (led_g !== 3'b001) begin bad++; $display("[TB] FAIL rr_home: got %b, expected 001", led_g); end
    endtask

    task automatic test_reset_mid_green();
        exp_q.push_back(2);
        sensor = 3'b100;
        @(negedge clk);
        sensor = 3'b000;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (led_g[2] === 1'b1) break;
        end
        total++; if (led_g[2] !== 1'b1) begin bad++; $display("[TB] FAIL wait_road2: got led_g=%b, expected road 2 green", led_g); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (led_r !== 3'b111) begin bad++; $display("[TB] FAIL midrst_red: got %b, expected 111", led_r); end
        total++; if (led_g !== 3'b000) begin bad++; $display("[TB] FAIL midrst_green: got %b, expected 000", led_g); end
        total++; if (active_road !== 2'd0) begin bad++; $display("[TB] FAIL midrst_active: got %0d, expected 0", active_road); end
        exp_q.push_back(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (led_g !== 3'b001) begin bad++; $display("[TB] FAIL midrst_recover: got %b, expected 001", led_g); end
    endtask

`ifdef TL_FLASH_MODE_EN
    task automatic test_flash();
        @(negedge clk);
        flash_req = 1'b1;
        @(negedge clk);
        total++; if (led_y !== 3'b001) begin bad++; $display("[TB] FAIL flash_yellow1: got %b, expected 001", led_y); end
        total++; if (phase_done !== 1'b1) begin bad++; $display("[TB] FAIL flash_pulse: got %b, expected 1", phase_done); end
        @(negedge clk);
        total++; if (led_y !== 3'b001) begin bad++; $display("[TB] FAIL flash_yellow2: got %b, expected 001", led_y); end
        @(negedge clk);
        total++; if ({led_r, led_y, led_g} !== 9'b000_111_000) begin bad++; $display("[TB] FAIL flash_on: got r=%b y=%b g=%b, expected 000 111 000", led_r, led_y, led_g); end
        @(negedge clk);
        total++; if (led_y !== 3'b000) begin bad++; $display("[TB] FAIL flash_off: got %b, expected 000", led_y); end
        @(negedge clk);
        total++; if (led_y !== 3'b111) begin bad++; $display("[TB] FAIL flash_on2: got %b, expected 111", led_y); end
        flash_req = 1'b0;
        exp_q.push_back(0);
        @(negedge clk);
        total++; if ({led_r, led_y} !== 6'b111_000) begin bad++; $display("[TB] FAIL flash_exit: got r=%b y=%b, expected 111 000", led_r, led_y); end
        @(negedge clk);
        total++; if (led_g !== 3'b001) begin bad++; $display("[TB] FAIL flash_home: got %b, expected 001", led_g); end
    endtask
`endif

    initial begin
        test_reset();
        test_hold();
        test_single_demand();
        test_max_green();
        test_round_robin();
        test_reset_mid_green();
`ifdef TL_FLASH_MODE_EN
        test_flash();
`endif
        @(negedge clk);
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL queue_empty: got %0d pending, expected 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
